leglite_fetch_stage: RTL
========================

Name: leglite_fetch_stage

Overview:
- Instruction-fetch front end for the LEGLite CPU; sits between the instruction memory (IM) and the decode/execute datapath.
- Owns the PC register and drives the IM address.
- Captures the returned 16-bit instruction into an IF/ID holding register with a valid bit.
- Handles sequential fetch, redirect (branch/jump), stall, and a halt state.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential fetch (16-bit instructions).
- HALT_INSTR, 16'hFFFF, instruction encoding that stops fetch.
- NOP_INSTR, 16'h0000, value placed in if_instr when the stage is flushed or empty.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- idata  input  16  instruction word from IM for address iaddr (combinational IM, same cycle).
- iaddr  output  16  IM address; always equal to the current PC register.
- redirect  input  1  take branch_target as the next PC.
- branch_target  input  16  redirect destination; bit 0 is forced to 0 internally.
- stall  input  1  hold the PC and the IF/ID register.
- if_instr  output  16  latched instruction for decode.
- if_pc  output  16  address from which if_instr was fetched.
- if_valid  output  1  if_instr is a real instruction.
- halted  output  1  stage is in the HALT state.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - pc = RESET_PC, if_instr = NOP_INSTR, if_pc = 16'h0000, if_valid = 0, halted = 0.
  - State = BOOT.
- iaddr = pc, combinational; no extra latency. The IM word for pc is captured on the next rising edge, so one-cycle fetch latency.
- FSM states: BOOT, RUN, HALT.
  - BOOT: first edge after reset deasserts. Captures idata/pc into IF/ID with if_valid = 1, updates pc per the next-PC rules, goes to RUN.
  - RUN: per-edge priority is reset > redirect > stall > sequential.
    - redirect=1: pc <= {branch_target[15:1],1'b0}; if_instr <= NOP_INSTR; if_valid <= 0. The fetched word is discarded (flush). Stall is ignored that cycle.
    - stall=1, redirect=0: pc, if_instr, if_pc and if_valid all hold.
    - Otherwise: if_instr <= idata; if_pc <= pc; if_valid <= 1; pc <= pc + PC_STEP.
  - RUN -> HALT: in the sequential case, when idata == HALT_INSTR. The HALT_INSTR word is latched (if_valid = 1) and pc still advances. From the next edge on, if_valid = 0 and if_instr = NOP_INSTR.
  - HALT: pc frozen; redirect and stall ignored; halted = 1; exits only on reset.
- Arithmetic: 16-bit unsigned. pc wraps 16'hFFFE + 2 -> 16'h0000 with no flag.
- Boundary cases:
  - redirect to the current pc is legal and refetches that address.
  - redirect and stall together: redirect wins.
  - stall held across many cycles is legal; outputs stay stable.
  - redirect while in BOOT follows the RUN redirect rule, then goes to RUN.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count [15:0], reset to 0.
  - Increments by 1 on every edge where a valid instruction is latched (sequential, BOOT, and HALT_INSTR capture). Does not increment on stall, redirect, or in HALT.
  - Wraps 16'hFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then run with IM[0,2,4] = 16'h1234, 16'h5678, 16'h9ABC -> after edges 1–3: if_pc = 0, 2, 4; if_instr matches; if_valid = 1; iaddr = 2, 4, 6.
- stall=1 for 3 cycles at pc = 16'h0006 -> iaddr stays 6, if_instr/if_pc unchanged; fetch resumes at 6 after stall drops.
- redirect=1 with branch_target = 16'h0041 and stall=1 the same cycle -> next iaddr = 16'h0040, if_valid = 0; following edge if_pc = 16'h0040, if_valid = 1.
- Force pc = 16'hFFFE via redirect, then sequential -> if_pc = 16'hFFFE, iaddr wraps to 16'h0000.
- IM[8] = 16'hFFFF -> if_instr = FFFF with if_valid = 1, then halted = 1, if_valid = 0, iaddr frozen at 16'h000A, redirect ignored; reset asserted mid-HALT -> immediate return to pc = 0, halted = 0.
- FETCH_COUNT_EN defined, run 5 fetches with 1 stall and 1 redirect -> fetch_count = 4; undefined -> build has no fetch_count port.

Source files
------------

// File: rtl/leglite_fetch_stage.sv
// leglite_fetch_stage: instruction-fetch front end for the LEGLite CPU.
// Owns the PC, drives the instruction-memory address and captures the
// returned 16-bit word into an IF/ID holding register with a valid bit.
// Handles sequential fetch, redirect (flush), stall and a terminal HALT state.
//
// Ports:
//   clock          system clock, rising-edge
//   reset          asynchronous active-high reset
//   idata          instruction word from IM for address iaddr (same cycle)
//   iaddr          IM address, always the current PC
//   redirect       load branch_target (bit 0 cleared) into the PC, flush IF/ID
//   branch_target  redirect destination
//   stall          hold PC and IF/ID
//   if_instr       latched instruction for decode
//   if_pc          address if_instr was fetched from
//   if_valid       if_instr is a real instruction
//   halted         stage is in HALT
//   fetch_count    (only with FETCH_COUNT_EN) number of valid captures
//
// Optional feature macro: FETCH_COUNT_EN adds the fetch_count output.
module leglite_fetch_stage #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int unsigned PC_STEP    = 2,
    parameter logic [15:0] HALT_INSTR = 16'hFFFF,
    parameter logic [15:0] NOP_INSTR  = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] idata,
    output logic [15:0] iaddr,
    input  logic        redirect,
    input  logic [15:0] branch_target,
    input  logic        stall,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_COUNT_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    localparam int unsigned XLEN = 16;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_seq;
    logic [XLEN-1:0]   pc_redirect;

    // IM is combinational: the address is the PC register itself.
    assign iaddr       = pc;
    assign pc_seq      = pc + XLEN'(PC_STEP);
    assign pc_redirect = {branch_target[XLEN-1:1], 1'b0};

    // Single-process FSM; BOOT follows the RUN rules for its first edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            if_instr <= NOP_INSTR;
            if_pc    <= 16'h0000;
            if_valid <= 1'b0;
            halted   <= 1'b0;
`ifdef FETCH_COUNT_EN
            fetch_count <= 16'h0000;
`endif
        end else begin
            case (state)
                BOOT, RUN: begin
                    if (redirect) begin
                        // Flush: the word fetched this cycle is discarded.
                        pc       <= pc_redirect;
                        if_instr <= NOP_INSTR;
                        if_valid <= 1'b0;
                        state    <= RUN;
                    end else if (!stall) begin
                        pc       <= pc_seq;
                        if_instr <= idata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
`ifdef FETCH_COUNT_EN
                        fetch_count <= fetch_count + 16'd1;
`endif
                        // The halt word itself is delivered as valid.
                        if (idata == HALT_INSTR) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                HALT: begin
                    // Terminal until reset: PC frozen, IF/ID drained.
                    if_instr <= NOP_INSTR;
                    if_valid <= 1'b0;
                    halted   <= 1'b1;
                end
                default: begin
                    state    <= BOOT;
                    if_instr <= NOP_INSTR;
                    if_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
